pipelined_shifter: RTL

- Parametrised, pipelined successor to the 16-bit combinational left-rotator used by the ALU.
- Supports five shift/rotate modes at any power-of-two width.
- Uses one registered log-stage per count bit, with a valid/ready handshake and bubble-collapsing backpressure.
- Sits between the execute-stage operand mux and the ALU result mux; a TAG travels with each operation so the consumer can match results.

---
 rtl/shifter_pkg.sv | 28 ++
 rtl/shift_stage.sv | 109 ++++++++++
 rtl/pipelined_shifter.sv | 111 +++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the pipelined shifter: shift/rotate mode encodings
// (as an enum and as plain localparams for legacy code) and a legality helper.
// No ports.
// -----------------------------------------------------------------------------
package shifter_pkg;

   typedef enum logic [2:0] {
      SH_ROL = 3'b000,
      SH_SLL = 3'b001,
      SH_ROR = 3'b010,
      SH_SRL = 3'b011,
      SH_SRA = 3'b100
   } shift_op_e;

   localparam logic [2:0] OP_ROL = 3'b000;
   localparam logic [2:0] OP_SLL = 3'b001;
   localparam logic [2:0] OP_ROR = 3'b010;
   localparam logic [2:0] OP_SRL = 3'b011;
   localparam logic [2:0] OP_SRA = 3'b100;

   // Encodings 101..111 are reserved; everything up to SRA is a real mode.
   function automatic logic is_legal_op(input logic [2:0] op);
      return (op <= OP_SRA);
   endfunction

endpackage

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// One log-stage of the pipelined shifter: conditionally shifts/rotates the
// incoming operand by SHAMT (a power of two) and registers the result together
// with the remaining operation context.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   i_valid         upstream slot holds an operation
//   i_down_ready    the downstream stage will take this stage's contents now
//   o_load          this stage loads this cycle (also the upstream ready)
//   i_data/i_cnt/i_op/i_tag/i_illegal   upstream operation context
//   o_valid/o_data/o_cnt/o_op/o_tag/o_illegal  registered operation context
//
// Handshake: a slot moves from upstream into this stage when o_load is high;
// o_load is high whenever the stage is empty or its contents leave this same
// cycle, so bubbles are squeezed out rather than propagated.
// -----------------------------------------------------------------------------
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4,
   parameter int SHAMT = 1,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   input  logic             i_down_ready,
   output logic             o_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic [CNT_W-1:0] i_cnt,
   input  logic [2:0]       i_op,
   input  logic [TAG_W-1:0] i_tag,
   input  logic             i_illegal,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [CNT_W-1:0] o_cnt,
   output logic [2:0]       o_op,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_illegal
);

   // Which count bit this stage is responsible for.
   localparam int BIT = $clog2(SHAMT);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_op;
   logic [TAG_W-1:0] r_tag;
   logic             r_illegal;

   shift_op_e        w_mode;
   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] w_next;

   assign w_mode = shift_op_e'(i_op);

   always_comb begin
      w_shifted = i_data;
      case (w_mode)
         SH_ROL:  w_shifted = (i_data << SHAMT) | (i_data >> (WIDTH - SHAMT));
         SH_SLL:  w_shifted = i_data << SHAMT;
         SH_ROR:  w_shifted = (i_data >> SHAMT) | (i_data << (WIDTH - SHAMT));
         SH_SRL:  w_shifted = i_data >> SHAMT;
         // The operand MSB survives every arithmetic step, so filling from the
         // current MSB is the same as filling from the original sign bit.
         SH_SRA:  w_shifted = $signed(i_data) >>> SHAMT;
         default: w_shifted = i_data;
      endcase
   end

   // Illegal ops behave as cnt=0 all the way through.
   assign w_next = (i_cnt[BIT] && !i_illegal) ? w_shifted : i_data;

   assign o_load = !r_valid || i_down_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_cnt     <= '0;
         r_op      <= '0;
         r_tag     <= '0;
         r_illegal <= 1'b0;
      end else if (o_load) begin
         r_valid <= i_valid;
         // Payload only changes when a real operation arrives; a bubble
         // just clears the valid bit.
         if (i_valid) begin
            r_data    <= w_next;
            r_cnt     <= i_cnt;
            r_op      <= i_op;
            r_tag     <= i_tag;
            r_illegal <= i_illegal;
         end
      end
   end

   assign o_valid   = r_valid;
   assign o_data    = r_data;
   assign o_cnt     = r_cnt;
   assign o_op      = r_op;
   assign o_tag     = r_tag;
   assign o_illegal = r_illegal;

endmodule

// File: rtl/pipelined_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_shifter
// Pipelined shift/rotate unit (ROL, SLL, ROR, SRL, SRA) with one registered
// log-stage per count bit, a valid/ready handshake on both sides and
// bubble-collapsing backpressure. A tag travels with each operation.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    input handshake; transfer when both are high
//   in_data, in_cnt        operand and shift amount (0..WIDTH-1)
//   in_op                  000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 SRA,
//                          101..111 illegal (data passes unshifted)
//   in_tag                 opaque sideband, returned with the result
//   out_valid / out_ready  output handshake; transfer when both are high
//   out_data, out_tag      result and its tag, straight from the last stage
//   out_zero               out_data == 0 (meaningful only with out_valid)
//   out_illegal            the operation used a reserved op encoding
//
// Latency is CNT_W cycles with no backpressure; throughput one op per cycle.
// in_ready depends only on stage valids and out_ready, never on in_valid.
// -----------------------------------------------------------------------------
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH),
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CNT_W-1:0] in_cnt,
   input  logic [2:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_zero,
   output logic             out_illegal
);

   // Index 0 is the pipeline input; index k+1 is the register of stage k.
   logic [CNT_W:0]   w_valid;
   logic [WIDTH-1:0] w_data    [CNT_W+1];
   logic [CNT_W-1:0] w_cnt     [CNT_W+1];
   logic [2:0]       w_op      [CNT_W+1];
   logic [TAG_W-1:0] w_tag     [CNT_W+1];
   logic [CNT_W:0]   w_illegal;

   logic [CNT_W-1:0] w_load;
   logic [CNT_W-1:0] w_down_ready;

   assign w_valid[0]   = in_valid;
   assign w_data[0]    = in_data;
   assign w_cnt[0]     = in_cnt;
   assign w_op[0]      = in_op;
   assign w_tag[0]     = in_tag;
   assign w_illegal[0] = !is_legal_op(in_op);

   for (genvar k = 0; k < CNT_W; k++) begin : g_stage
      // Stage k+1 loads when it is empty or stage k+2 loads, and so on down to
      // out_ready. Unrolled, that is: out_ready, or any later stage is empty.
      // Written flat so no signal feeds back into its own vector.
      if (k == CNT_W - 1) begin : g_last
         assign w_down_ready[k] = out_ready;
      end else begin : g_mid
         assign w_down_ready[k] = out_ready | ~(&w_valid[CNT_W:k+2]);
      end

      shift_stage #(
         .WIDTH (WIDTH),
         .TAG_W (TAG_W),
         .SHAMT (1 << k),
         .CNT_W (CNT_W)
      ) u_stage (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_valid      (w_valid[k]),
         .i_down_ready (w_down_ready[k]),
         .o_load       (w_load[k]),
         .i_data       (w_data[k]),
         .i_cnt        (w_cnt[k]),
         .i_op         (w_op[k]),
         .i_tag        (w_tag[k]),
         .i_illegal    (w_illegal[k]),
         .o_valid      (w_valid[k+1]),
         .o_data       (w_data[k+1]),
         .o_cnt        (w_cnt[k+1]),
         .o_op         (w_op[k+1]),
         .o_tag        (w_tag[k+1]),
         .o_illegal    (w_illegal[k+1])
      );
   end

   assign in_ready    = w_load[0];

   assign out_valid   = w_valid[CNT_W];
   assign out_data    = w_data[CNT_W];
   assign out_tag     = w_tag[CNT_W];
   assign out_illegal = w_illegal[CNT_W];
   assign out_zero    = ~|w_data[CNT_W];

   // Count/op leaving the last stage and the inner load enables have no
   // consumer; they are part of the uniform stage interface.
   logic w_unused_tail;
   assign w_unused_tail = ^{w_cnt[CNT_W], w_op[CNT_W], w_load};

endmodule
